// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory and writeback control.
// Holds the pc, instruction register, retired-instruction counter and an absorbing trap state.
module instr_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic [6:0]  opcode,
  input  logic        dec_rg_we,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 7;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_FENCE  = 7'b0001111;
  localparam logic [OPC_W-1:0] OP_SYSTEM = 7'b1110011;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic            illegal_q, illegal_d;

  logic            op_legal;
  logic            op_mem;
  logic            op_nop;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_pc;
  logic [XLEN-1:0] jalr_pc;
  logic [XLEN-1:0] exec_pc;

  // Opcode classification of the instruction currently held in ir
  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_OPIMM, OP_OP, OP_FENCE, OP_SYSTEM: op_legal = 1'b1;
      default:                                         op_legal = 1'b0;
    endcase
  end

  assign op_mem = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign op_nop = (opcode == OP_FENCE) || (opcode == OP_SYSTEM);

  // Successor pc; all adds wrap modulo 2^32
  always_comb begin
    seq_pc  = pc_q + XLEN'(4);
    rel_pc  = pc_q + imm;
    jalr_pc = (rs1_val + imm) & ~XLEN'(1);
    case (opcode)
      OP_JAL:    exec_pc = rel_pc;
      OP_JALR:   exec_pc = jalr_pc;
      OP_BRANCH: exec_pc = branch_taken ? rel_pc : seq_pc;
      default:   exec_pc = seq_pc;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    next_pc_d = next_pc_q;
    illegal_d = illegal_q;

    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = op_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        next_pc_d = exec_pc;
        if (exec_pc[1]) begin
          state_d = S_TRAP;
        end else if (op_mem) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        pc_d      = next_pc_q;
        instret_d = instret_q + XLEN'(1);
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase

    if (state_d == S_TRAP) begin
      illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      instret_q <= '0;
      next_pc_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      next_pc_q <= next_pc_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset parks the FSM in FETCH, so the fetch request is gated until reset releases
  assign imem_req  = resetn && (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign dmem_req  = (state_q == S_MEM);
  assign dmem_we   = (state_q == S_MEM) && (opcode == OP_STORE);
  assign rf_we     = (state_q == S_WB) && dec_rg_we && !op_nop;
  assign ir        = ir_q;
  assign pc        = pc_q;
  assign state     = state_q;
  assign illegal   = illegal_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized scoreboard bench for instr_sequencer: a memory/decoder responder issues
// instructions and predicts their outcome; a monitor checks the DUT against those predictions.
`timescale 1ns/1ps
module tb_instr_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic        clk = 1'b0;
  logic        resetn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic        dec_rg_we;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic        branch_taken;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] instret;

  instr_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .resetn(resetn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .opcode(opcode), .dec_rg_we(dec_rg_we), .imm(imm),
    .rs1_val(rs1_val), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc(pc), .state(state), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  // Bench-side decoder: I-type immediate for every format keeps stimulus simple
  assign opcode    = ir[6:0];
  assign imm       = {{20{ir[31]}}, ir[31:20]};
  assign dec_rg_we = opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OPIMM, OP_OP};

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic        taken;
    int unsigned fwait;
    int unsigned mwait;
  } stim_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] instret;
    logic        trap;
    logic        mem;
    logic        we;
    logic        rf_we;
    int unsigned lat;
  } exp_t;

  stim_t       stim_q[$];
  exp_t        exp_q[$];
  logic [31:0] fetch_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_instret;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h t=%0t", name, act, req, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: actual=missing required=present t=%0t", name, $time);
  endtask

  // Architectural prediction of one instruction, made when it is handed to the DUT
  function automatic void model_issue(input stim_t s);
    exp_t        e;
    logic [6:0]  op;
    logic [31:0] im;
    logic [31:0] tgt;
    logic        legal;
    op    = s.instr[6:0];
    im    = {{20{s.instr[31]}}, s.instr[31:20]};
    legal = op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                       OP_STORE, OP_OPIMM, OP_OP, OP_FENCE, OP_SYSTEM};
    case (op)
      OP_JAL:    tgt = m_pc + im;
      OP_JALR:   tgt = (s.rs1 + im) & 32'hFFFF_FFFE;
      OP_BRANCH: tgt = s.taken ? m_pc + im : m_pc + 32'd4;
      default:   tgt = m_pc + 32'd4;
    endcase
    e.instr   = s.instr;
    e.pc      = m_pc;
    e.instret = m_instret;
    e.trap    = !legal || tgt[1];
    e.mem     = !e.trap && (op == OP_LOAD || op == OP_STORE);
    e.we      = (op == OP_STORE);
    e.rf_we   = !e.trap && (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OPIMM, OP_OP});
    e.lat     = 4 + s.fwait + (e.mem ? 1 + s.mwait : 0);
    if (!e.trap) begin
      m_pc      = tgt;
      m_instret = m_instret + 32'd1;
      fetch_q.push_back(tgt);
    end
    exp_q.push_back(e);
  endfunction

  // Responder: memories plus register-file read data, driven on the falling edge
  stim_t       cur;
  logic        rsp_busy = 1'b0;
  int unsigned fw_left  = 0;
  int unsigned mw_left  = 0;

  initial begin
    imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; rs1_val = '0; branch_taken = 1'b0;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (!resetn) begin
        rsp_busy = 1'b0;
      end else begin
        if (imem_req) begin
          if (!rsp_busy && stim_q.size() > 0) begin
            cur = stim_q.pop_front();
            rsp_busy = 1'b1;
            fw_left = cur.fwait;
          end
          if (rsp_busy) begin
            if (fw_left == 0) begin
              imem_ack     = 1'b1;
              imem_rdata   = cur.instr;
              rs1_val      = cur.rs1;
              branch_taken = cur.taken;
              mw_left      = cur.mwait;
              model_issue(cur);
              rsp_busy     = 1'b0;
            end else begin
              fw_left--;
            end
          end
        end else begin
          imem_ack = 1'($urandom_range(0, 1));
        end
        if (dmem_req) begin
          if (mw_left == 0) dmem_ack = 1'b1;
          else mw_left--;
        end else begin
          dmem_ack = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: compares DUT behaviour against the scoreboard each cycle
  logic [2:0]  prev_state = 3'd7;
  int unsigned cyc = 0;
  int unsigned t0  = 0;
  logic        seen_mem = 1'b0;
  exp_t        e_m;
  exp_t        trap_e;

  initial begin
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (!resetn) begin
        prev_state = 3'd7;
      end else begin
        if (state == 3'd0 && prev_state != 3'd0) begin
          t0 = cyc;
          seen_mem = 1'b0;
        end
        if (state != 3'd4) chk("rf_we_idle", 32'(rf_we), 32'd0);
        if (state != 3'd5) chk("illegal_clear", 32'(illegal), 32'd0);
        case (state)
          3'd0: begin
            chk("imem_req_fetch", 32'(imem_req), 32'd1);
            if (fetch_q.size() == 0) fail_now("fetch_addr_expect");
            else begin
              chk("fetch_addr", imem_addr, fetch_q[0]);
              if (imem_ack) void'(fetch_q.pop_front());
            end
          end
          3'd1: begin
            if (exp_q.size() == 0) fail_now("ir_expect");
            else chk("ir_load", ir, exp_q[0].instr);
          end
          3'd2: ;
          3'd3: begin
            seen_mem = 1'b1;
            if (exp_q.size() == 0) fail_now("mem_expect");
            else chk("dmem_we", 32'(dmem_we), 32'(exp_q[0].we));
          end
          3'd4: begin
            if (exp_q.size() == 0) fail_now("retire_expect");
            else begin
              e_m = exp_q.pop_front();
              chk("retire_not_trap", 32'(e_m.trap), 32'd0);
              chk("retire_pc", pc, e_m.pc);
              chk("retire_instret", instret, e_m.instret);
              chk("retire_rf_we", 32'(rf_we), 32'(e_m.rf_we));
              chk("retire_mem_visit", 32'(seen_mem), 32'(e_m.mem));
              chk("retire_latency", cyc - t0 + 1, e_m.lat);
            end
          end
          3'd5: begin
            if (prev_state != 3'd5) begin
              if (exp_q.size() == 0) fail_now("trap_expect");
              else begin
                trap_e = exp_q.pop_front();
                chk("trap_expected", 32'(trap_e.trap), 32'd1);
                chk("trap_illegal", 32'(illegal), 32'd1);
              end
            end else begin
              chk("trap_imem_req", 32'(imem_req), 32'd0);
              chk("trap_dmem_req", 32'(dmem_req), 32'd0);
              chk("trap_illegal_sticky", 32'(illegal), 32'd1);
              chk("trap_pc_frozen", pc, trap_e.pc);
              chk("trap_ir_frozen", ir, trap_e.instr);
              chk("trap_instret_frozen", instret, trap_e.instret);
            end
          end
          default: chk("state_code", 32'(state), 32'd0);
        endcase
        prev_state = state;
      end
    end
  end

  task automatic push(input logic [31:0] instr, input logic [31:0] rs1, input logic taken,
                      input int unsigned fw, input int unsigned mw);
    stim_t s;
    s.instr = instr; s.rs1 = rs1; s.taken = taken; s.fwait = fw; s.mwait = mw;
    stim_q.push_back(s);
  endtask

  task automatic enter_reset();
    resetn = 1'b0;
    #1;
    stim_q.delete(); exp_q.delete(); fetch_q.delete();
    m_pc = RESET_PC; m_instret = '0;
    fetch_q.push_back(RESET_PC);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_ir", ir, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
  endtask

  task automatic leave_reset();
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    resetn = 1'b1;
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n = 0;
    while ((stim_q.size() != 0 || rsp_busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk); #2; n++;
    end
    if (stim_q.size() != 0 || rsp_busy || exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic wait_trap(input int unsigned budget);
    int unsigned n = 0;
    while (state != 3'd5 && n < budget) begin
      @(negedge clk); #2; n++;
    end
    if (state != 3'd5) fail_now("trap_timeout");
  endtask

  logic [6:0] legal_ops [11] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                                 OP_STORE, OP_OPIMM, OP_OP, OP_FENCE, OP_SYSTEM};

  initial begin
    logic [6:0]  op;
    logic [11:0] im12;
    logic [31:0] rs1;
    int unsigned n;
    resetn = 1'b1;
    #3;
    enter_reset();
    leave_reset();

    // Directed: ADDI, BEQ taken/not-taken from 0x10, stalled fetch, stalled load
    push(32'h0010_0093, 32'd0, 1'b0, 0, 0);
    repeat (3) push(32'h0040_0093, 32'd0, 1'b0, 0, 0);
    push(32'hFF00_0063, 32'd0, 1'b1, 0, 0);
    repeat (4) push(32'h0040_0093, 32'd0, 1'b0, 0, 0);
    push(32'hFF00_0063, 32'd0, 1'b0, 0, 0);
    push(32'h0010_0093, 32'd0, 1'b0, 3, 0);
    push({12'h008, 13'h0, OP_LOAD}, 32'd0, 1'b0, 0, 2);
    push({12'h00C, 13'h0, OP_FENCE}, 32'd0, 1'b0, 0, 0);
    wait_drain(500);

    // Random legal, aligned program
    for (int i = 0; i < 300; i++) begin
      op   = legal_ops[$urandom_range(0, 10)];
      im12 = 12'($urandom) & 12'hFFC;
      rs1  = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      push({im12, 13'($urandom), op}, rs1, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
           ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
    end
    wait_drain(20000);

    // Reset during a stalled store
    push({12'h010, 13'h0, OP_STORE}, 32'd0, 1'b0, 0, 20);
    n = 0;
    do begin @(negedge clk); #2; n++; end while (!dmem_req && n < 200);
    if (!dmem_req) fail_now("store_mem_timeout");
    enter_reset();
    leave_reset();
    push(32'h0010_0093, 32'd0, 1'b0, 0, 0);
    wait_drain(200);

    // Misaligned JALR target traps
    push({12'h002, 13'h0, OP_JALR}, 32'h0000_0100, 1'b0, 0, 0);
    wait_trap(200);
    repeat (10) @(negedge clk);

    // Illegal opcode traps
    @(negedge clk); #2;
    enter_reset();
    leave_reset();
    push(32'h0000_007F, 32'd0, 1'b0, 0, 0);
    wait_trap(200);
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
